mult_recon: RTL

- Sequential shift-add multiplier that rebuilds a dividend from a quotient/remainder pair: y = q*d + r.
- Inverse of the restoring divider. Used to self-check divider results, and as the "multiply" half of the arithmetic unit.
- Built from the same datapath style as the divider: operand registers, shift register, adder, counter and a small controller FSM.

---
 rtl/mult_recon.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mult_recon.sv
// mult_recon: sequential shift-add multiplier that rebuilds a dividend from a
// quotient/remainder pair, y = q*d + r. Companion to the restoring divider:
// operand registers, a 2N+1 bit product/shift register, one adder, an
// iteration counter and a four-state controller.
module mult_recon #(
   parameter int N = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   q,
   input  logic [N-1:0]   d,
   input  logic [N-1:0]   r,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] y,
   output logic           err
);

   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ADDR = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic             accept_s;
   logic             last_s;

   logic [N-1:0]     d_r;
   logic [N-1:0]     r_r;
   logic [2*N:0]     p_r;
   logic [CNT_W-1:0] cnt_r;
   logic             err_pend_r;
   logic [2*N-1:0]   y_r;
   logic             err_r;
   logic             ready_r;
   logic             busy_r;
   logic             done_r;

   logic [N:0]       add_s;
   logic [2*N:0]     step_s;
   logic [2*N:0]     shifted_s;
   logic [2*N:0]     sum_s;
   logic             err_chk_s;

   assign ready = ready_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign y     = y_r;
   assign err   = err_r;

   // Controller next state; start is honoured only in IDLE and DONE.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      last_s       = (cnt_r == CNT_W'(N - 1));
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = CALC;
               accept_s     = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         CALC: begin
            if (last_s) begin
               state_next_s = ADDR;
            end else begin
               state_next_s = CALC;
            end
         end
         ADDR: begin
            state_next_s = DONE;
         end
         DONE: begin
            if (start) begin
               state_next_s = CALC;
               accept_s     = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Datapath arithmetic: conditional add into the upper half, shift, final addend.
   always_comb begin
      add_s     = p_r[2*N:N] + {1'b0, d_r};
      step_s    = p_r;
      if (p_r[0]) begin
         step_s = {add_s, p_r[N-1:0]};
      end else begin
         step_s = p_r;
      end
      shifted_s = {1'b0, step_s[2*N:1]};
      sum_s     = p_r + {{(N+1){1'b0}}, r_r};
      err_chk_s = (d == {N{1'b0}}) | ({1'b0, r} >= {1'b0, d});
   end

   // Datapath registers; y/err only move on the ADDR edge so they hold across a new run.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_r        <= {N{1'b0}};
         r_r        <= {N{1'b0}};
         p_r        <= {(2*N+1){1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         err_pend_r <= 1'b0;
         y_r        <= {(2*N){1'b0}};
         err_r      <= 1'b0;
      end else if (accept_s) begin
         d_r        <= d;
         r_r        <= r;
         p_r        <= {{(N+1){1'b0}}, q};
         cnt_r      <= {CNT_W{1'b0}};
         err_pend_r <= err_chk_s;
      end else if (state_r == CALC) begin
         p_r        <= shifted_s;
         cnt_r      <= cnt_r + CNT_W'(1);
      end else if (state_r == ADDR) begin
         p_r        <= sum_s;
         y_r        <= sum_s[2*N-1:0];
         err_r      <= err_pend_r;
      end else begin
         p_r        <= p_r;
      end
   end

   // Status flags registered from the next state so they line up with state_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         ready_r <= (state_next_s == IDLE) || (state_next_s == DONE);
         busy_r  <= (state_next_s == CALC) || (state_next_s == ADDR);
         done_r  <= (state_next_s == DONE);
      end
   end

endmodule
